// File: rtl/baud_tick_gen.sv
// Baud tick generator: divides clk by (ref_active+1) into tick16, and by OVS*(ref_active+1) into tickbit.
// Optional mid-bit strobe enabled by defining BAUD_MIDBIT_EN.
module baud_tick_gen #(
    parameter int unsigned WIDTH       = 9,
    parameter int unsigned DEFAULT_REF = 324,
    parameter int unsigned OVS         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         refer,
    input  logic                     restart,
    output logic                     tick16,
    output logic                     tickbit,
    output logic                     midbit,
    output logic [$clog2(OVS)-1:0]   phase,
    output logic [WIDTH-1:0]         ref_active
);

    localparam int unsigned PW = $clog2(OVS);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVS - 1);

    logic [WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             tick16_q, tick16_d;
    logic             tickbit_q, tickbit_d;
    logic             wrap;

    // The shadow divisor only moves at wrap, restart or while disabled, so the
    // counter can never overshoot it.
    assign wrap = (div_cnt_q == ref_q);

    always_comb begin
        div_cnt_d = div_cnt_q;
        ref_d     = ref_q;
        phase_d   = phase_q;
        tick16_d  = 1'b0;
        tickbit_d = 1'b0;
        if (restart) begin
            div_cnt_d = '0;
            phase_d   = '0;
            ref_d     = refer;
        end else if (!en) begin
            div_cnt_d = '0;
            phase_d   = '0;
            ref_d     = refer;
        end else if (wrap) begin
            div_cnt_d = '0;
            ref_d     = refer;
            phase_d   = phase_q + PW'(1);
            tick16_d  = 1'b1;
            tickbit_d = (phase_q == PHASE_LAST);
        end else begin
            div_cnt_d = div_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            ref_q     <= WIDTH'(DEFAULT_REF);
            phase_q   <= '0;
            tick16_q  <= 1'b0;
            tickbit_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ref_q     <= ref_d;
            phase_q   <= phase_d;
            tick16_q  <= tick16_d;
            tickbit_q <= tickbit_d;
        end
    end

`ifdef BAUD_MIDBIT_EN
    localparam logic [PW-1:0] PHASE_MID = PW'(OVS / 2 - 1);

    logic midbit_q, midbit_d;

    always_comb begin
        midbit_d = 1'b0;
        if (!restart && en && wrap && (phase_q == PHASE_MID)) begin
            midbit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            midbit_q <= 1'b0;
        end else begin
            midbit_q <= midbit_d;
        end
    end

    assign midbit = midbit_q;
`else
    assign midbit = 1'b0;
`endif

    assign tick16     = tick16_q;
    assign tickbit    = tickbit_q;
    assign phase      = phase_q;
    assign ref_active = ref_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: expected tick times are queued when stimulus is applied
// and popped when the DUT pulses.
module tb_baud_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [8:0] refer;
    logic       restart;
    logic       tick16;
    logic       tickbit;
    logic       midbit;
    logic [3:0] phase;
    logic [8:0] ref_active;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];

    baud_tick_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .refer      (refer),
        .restart    (restart),
        .tick16     (tick16),
        .tickbit    (tickbit),
        .midbit     (midbit),
        .phase      (phase),
        .ref_active (ref_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return tick16;
            1:       return tickbit;
            default: return midbit;
        endcase
    endfunction

    // Returns the cycle stamp of the next pulse, or -1 if none within bound.
    task automatic wait_sig(input int sel, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sel_val(sel)) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_next(input int sel, input string tag);
        int t;
        wait_sig(sel, 2000, t);
        check(tag, t, exp_q.pop_front());
    endtask

    initial begin
        int c_en, t0, t1, r, c_re, c, n_tick, n_bit, n_phase, t;
        rst = 1'b0; en = 1'b0; refer = 9'd26; restart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tick16", int'(tick16), 0);
        check("rst_tickbit", int'(tickbit), 0);
        check("rst_midbit", int'(midbit), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_ref_active", int'(ref_active), 324);

        // Disabled: shadow tracks refer live.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("dis_ref_track", int'(ref_active), 26);

        // refer=26: tick16 every 27, tickbit every 432.
        c_en = cyc; en = 1'b1;
        exp_q.push_back(c_en + 27);
        expect_next(0, "first_tick16");
        check("phase_after_first", int'(phase), 1);
        exp_q.push_back(c_en + 54);
        expect_next(0, "second_tick16");
        exp_q.push_back(c_en + 432);
        expect_next(1, "first_tickbit");
        check("tickbit_with_tick16", int'(tick16), 1);
        exp_q.push_back(c_en + 864);
        expect_next(1, "second_tickbit");
        check("ref_active_26", int'(ref_active), 26);

        // Switch to 324 at a wrap; takes effect at the following wrap.
        refer = 9'd324;
        exp_q.push_back(c_en + 891);
        wait_sig(0, 2000, t0);
        check("tick16_before_324", t0, exp_q.pop_front());
        check("ref_active_324", int'(ref_active), 324);

        // Change to 53 at div_cnt=100: current 325-clock period still completes.
        goto(t0 + 100);
        refer = 9'd53;
        goto(t0 + 324);
        check("ref_hold_midperiod", int'(ref_active), 324);
        check("no_early_tick", int'(tick16), 0);
        exp_q.push_back(t0 + 325);
        wait_sig(0, 2000, t1);
        check("period_325", t1, exp_q.pop_front());
        check("ref_active_53", int'(ref_active), 53);
        exp_q.push_back(t1 + 54);
        wait_sig(0, 2000, t1);
        check("period_54", t1, exp_q.pop_front());

        // Restart on the wrap edge suppresses the tick.
        goto(t1 + 53);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r = cyc;
        check("restart_no_tick", int'(tick16), 0);
        check("restart_phase", int'(phase), 0);
        exp_q.push_back(r + 54);
        expect_next(0, "tick_after_restart");

        // Drop en at phase 9 for 5 clocks.
        goto(r + 486 + 10);
        check("phase_9", int'(phase), 9);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("dis_phase", int'(phase), 0);
        check("dis_tick16", int'(tick16), 0);
        c_re = cyc; en = 1'b1;
        exp_q.push_back(c_re + 864);
        expect_next(1, "tickbit_after_reenable");
        check("phase_wrap_0", int'(phase), 0);

        // refer=0: tick every clock.
        en = 1'b0; refer = 9'd0;
        @(negedge clk);
        check("ref_active_0", int'(ref_active), 0);
        c = cyc; en = 1'b1;
        n_tick = 0; n_bit = 0; n_phase = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (tick16) n_tick++;
            if (tickbit) n_bit++;
            if (int'(phase) != (i % 16)) n_phase++;
        end
        check("ref0_tick16_count", n_tick, 32);
        check("ref0_tickbit_count", n_bit, 2);
        check("ref0_phase_errs", n_phase, 0);

        // Mid-bit strobe after restart with refer=26.
        refer = 9'd26;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r = cyc;
`ifdef BAUD_MIDBIT_EN
        exp_q.push_back(r + 216);
        wait_sig(2, 2000, t);
        check("midbit_first", t, exp_q.pop_front());
        check("midbit_with_tick16", int'(tick16), 1);
        exp_q.push_back(r + 648);
        expect_next(2, "midbit_second");
`else
        n_bit = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (midbit) n_bit++;
        end
        check("midbit_const0", n_bit, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
